// File: rtl/vec_exec_sequencer_pkg.sv
// Shared types and constants for the vector execute sequencer.
// Opcodes, flag bit positions, sequencer states, opcode check.
package vec_pkg;

  localparam logic [2:0] OP_MUL = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } seq_state_t;

  function automatic logic op_valid(
    input logic [2:0] op
  );
    return (op == OP_MUL) ||
           (op == OP_SUB) ||
           (op == OP_ADD);
  endfunction

endpackage

// File: rtl/vec_exec_sequencer_if.sv
// Upstream instruction and downstream result handshakes.
// master = issuer/consumer side, slave = sequencer side.
interface vec_exec_sequencer_if #(
  parameter int DW   = 16,
  parameter int VLEN = 8
);

  logic                in_valid;
  logic                in_ready;
  logic [2:0]          in_opcode;
  logic                in_scalar;
  logic [VLEN*DW-1:0]  in_vec_a;
  logic [VLEN*DW-1:0]  in_vec_b;
  logic                out_valid;
  logic                out_ready;
  logic [VLEN*DW-1:0]  out_result;
  logic [3:0]          out_flags;

  modport master (
    output in_valid,
    output in_opcode,
    output in_scalar,
    output in_vec_a,
    output in_vec_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_result,
    input  out_flags
  );

  modport slave (
    input  in_valid,
    input  in_opcode,
    input  in_scalar,
    input  in_vec_a,
    input  in_vec_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_result,
    output out_flags
  );

endinterface

// File: rtl/vec_exec_sequencer_flag_fold.sv
// Folds per-element {V,N,Z,C} flags into one flag nibble.
// Ports: flags_i (VLEN*4), opcode_i, scalar_i -> flags_o.
module vec_flag_fold
  import vec_pkg::*;
#(
  parameter int VLEN = 8
) (
  input  logic [VLEN*4-1:0] flags_i,
  input  logic [2:0]        opcode_i,
  input  logic              scalar_i,
  output logic [3:0]        flags_o
);

  logic z;
  logic n;
  logic v;
  logic c;

  always_comb begin
    z = 1'b1;
    n = 1'b0;
    v = 1'b0;
    c = 1'b0;
    for (int i = 0; i < VLEN; i++) begin
      if (i == 0 || !scalar_i) begin
        z &= flags_i[i*4+FLAG_Z];
        n |= flags_i[i*4+FLAG_N];
        v |= flags_i[i*4+FLAG_V];
        c |= flags_i[i*4+FLAG_C];
      end
    end
    flags_o         = '0;
    flags_o[FLAG_Z] = z;
    flags_o[FLAG_N] = n;
    flags_o[FLAG_V] = v;
    // lanes leave carry undefined on mul
    flags_o[FLAG_C] = c && (opcode_i != OP_MUL);
    // invalid ops yield a zero result; lane
    // flags may be X, so pin them here
    if (!op_valid(opcode_i)) begin
      flags_o         = '0;
      flags_o[FLAG_Z] = 1'b1;
    end
  end

endmodule

// File: rtl/vec_exec_sequencer.sv
// Issue stage feeding LANES combinational vector ALU lanes.
// Ports: clk, rst, bus (slave handshakes), lane_* to/from lanes.
module vec_exec_sequencer
  import vec_pkg::*;
#(
  parameter int DW    = 16,
  parameter int VLEN  = 8,
  parameter int LANES = 4
) (
  input  logic                clk,
  input  logic                rst,
  vec_exec_sequencer_if.slave bus,
  output logic [LANES*DW-1:0] lane_a,
  output logic [LANES*DW-1:0] lane_b,
  output logic [2:0]          lane_opcode,
  output logic                lane_scalar,
  input  logic [LANES*DW-1:0] lane_result,
  input  logic [LANES*4-1:0]  lane_flags
);

  localparam int BEATS = VLEN / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  seq_state_t         state_q, state_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [2:0]         opc_q, opc_d;
  logic               scl_q, scl_d;
  logic [VLEN*DW-1:0] a_q, a_d;
  logic [VLEN*DW-1:0] b_q, b_d;
  logic [VLEN*DW-1:0] res_q, res_d;
  logic [VLEN*4-1:0]  flg_q, flg_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      opc_q   <= '0;
      scl_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      opc_q   <= opc_d;
      scl_q   <= scl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    opc_d   = opc_q;
    scl_d   = scl_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flg_d   = flg_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = EXEC;
          beat_d  = '0;
          opc_d   = bus.in_opcode;
          scl_d   = bus.in_scalar;
          a_d     = bus.in_vec_a;
          b_d     = bus.in_vec_b;
          res_d   = '0;
          flg_d   = '0;
        end
      end
      EXEC: begin
        for (int j = 0; j < LANES; j++) begin
          if (j == 0 || !scl_q) begin
            res_d[(int'(beat_q)*LANES+j)*DW +: DW] =
              lane_result[j*DW +: DW];
            flg_d[(int'(beat_q)*LANES+j)*4 +: 4] =
              lane_flags[j*4 +: 4];
          end
        end
        // scalar ops issue a single beat
        if (scl_q || beat_q == BW'(BEATS-1)) begin
          state_d = DONE;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    lane_a = '0;
    lane_b = '0;
    if (state_q == EXEC) begin
      for (int j = 0; j < LANES; j++) begin
        if (j == 0 || !scl_q) begin
          lane_a[j*DW +: DW] =
            a_q[(int'(beat_q)*LANES+j)*DW +: DW];
          lane_b[j*DW +: DW] =
            b_q[(int'(beat_q)*LANES+j)*DW +: DW];
        end
      end
    end
  end

  assign lane_opcode    = opc_q;
  assign lane_scalar    = scl_q;
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = res_q;

  vec_flag_fold #(
    .VLEN (VLEN)
  ) u_fold (
    .flags_i  (flg_q),
    .opcode_i (opc_q),
    .scalar_i (scl_q),
    .flags_o  (bus.out_flags)
  );

endmodule

// File: tb/tb_vec_exec_sequencer.sv
// Directed bench for vec_exec_sequencer with a Q7.8 lane model.
// Expected vectors and flags are hand-computed constants.
module tb_vec_exec_sequencer;

  logic          clk;
  logic          rst;
  logic [63:0]   lane_a;
  logic [63:0]   lane_b;
  logic [2:0]    lane_opcode;
  logic          lane_scalar;
  logic [63:0]   lane_result;
  logic [15:0]   lane_flags;
  logic [19:0]   tmp;

  int checks;
  int failures;

  vec_exec_sequencer_if #(.DW(16), .VLEN(8)) bus ();

  vec_exec_sequencer #(
    .DW    (16),
    .VLEN  (8),
    .LANES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .lane_a      (lane_a),
    .lane_b      (lane_b),
    .lane_opcode (lane_opcode),
    .lane_scalar (lane_scalar),
    .lane_result (lane_result),
    .lane_flags  (lane_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // returns {V,N,Z,C, result}
  function automatic logic [19:0] alu(
    input logic [2:0]  op,
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [16:0] s;
    logic [31:0] p;
    logic [15:0] r;
    logic        c;
    logic        v;
    case (op)
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0];
        c = s[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      3'b001: begin
        s = {1'b0, a} + {1'b0, ~b} + 17'd1;
        r = s[15:0];
        c = s[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      3'b000: begin
        p = $signed(a) * $signed(b);
        r = p[23:8];
        c = 1'b1;
        v = !(p[31:23] == 9'h000 || p[31:23] == 9'h1FF);
      end
      default: begin
        return {4'bxxxx, 16'h0000};
      end
    endcase
    return {v, r[15], (r == 16'h0000), c, r};
  endfunction

  always_comb begin
    lane_result = '0;
    lane_flags  = '0;
    tmp         = '0;
    for (int j = 0; j < 4; j++) begin
      tmp = alu(lane_opcode, lane_a[j*16 +: 16],
                lane_b[j*16 +: 16]);
      lane_result[j*16 +: 16] = tmp[15:0];
      lane_flags[j*4 +: 4]    = tmp[19:16];
    end
  end

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic issue(
    input logic [2:0]   op,
    input logic         scl,
    input logic [127:0] a,
    input logic [127:0] b
  );
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_scalar = scl;
    bus.in_vec_a  = a;
    bus.in_vec_b  = b;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.in_opcode = 3'b011;
    bus.in_scalar = ~scl;
    bus.in_vec_a  = '1;
    bus.in_vec_b  = '1;
  endtask

  task automatic wait_lat(input int lat, input string tag);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk($sformatf("%s_valid_c%0d", tag, c),
          128'(bus.out_valid), 128'(c == lat));
    end
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_rdy_back"}, 128'(bus.in_ready), 128'd1);
    chk({tag, "_vld_drop"}, 128'(bus.out_valid), 128'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_scalar = 1'b0;
    bus.in_vec_a  = '0;
    bus.in_vec_b  = '0;
    bus.out_ready = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_result", bus.out_result, 128'd0);
    chk("rst_flags", 128'(bus.out_flags), 128'd0);
    chk("rst_lane_a", 128'(lane_a), 128'd0);
    chk("rst_lane_b", 128'(lane_b), 128'd0);
    chk("rst_lane_op", 128'(lane_opcode), 128'd0);
    chk("rst_lane_scl", 128'(lane_scalar), 128'd0);
    rst = 1'b0;

    // vector add, then 5-cycle downstream stall
    issue(3'b010, 1'b0, {8{16'h0100}}, {8{16'h0080}});
    wait_lat(3, "vadd");
    chk("vadd_result", bus.out_result, {8{16'h0180}});
    chk("vadd_flags", 128'(bus.out_flags), 128'd0);
    bus.in_valid  = 1'b1;
    bus.in_opcode = 3'b001;
    bus.in_vec_a  = {8{16'h1111}};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", 128'(bus.out_valid), 128'd1);
      chk("stall_result", bus.out_result, {8{16'h0180}});
      chk("stall_flags", 128'(bus.out_flags), 128'd0);
      chk("stall_in_ready", 128'(bus.in_ready), 128'd0);
    end
    bus.in_valid = 1'b0;
    accept("vadd");

    // scalar mul with out_ready held high
    bus.out_ready = 1'b1;
    issue(3'b000, 1'b1,
          {{7{16'h5555}}, 16'h0180},
          {{7{16'h3333}}, 16'h0200});
    @(negedge clk);
    chk("smul_valid_c1", 128'(bus.out_valid), 128'd0);
    chk("smul_lane_a", 128'(lane_a), {112'd0, 16'h0180});
    chk("smul_lane_b", 128'(lane_b), {112'd0, 16'h0200});
    chk("smul_lane_scl", 128'(lane_scalar), 128'd1);
    @(negedge clk);
    chk("smul_valid_c2", 128'(bus.out_valid), 128'd1);
    chk("smul_result", bus.out_result, {112'd0, 16'h0300});
    chk("smul_flags", 128'(bus.out_flags), 128'd0);
    @(negedge clk);
    chk("smul_auto_acc", 128'(bus.out_valid), 128'd0);
    chk("smul_rdy_back", 128'(bus.in_ready), 128'd1);
    bus.out_ready = 1'b0;

    // vector add, element 5 overflows
    issue(3'b010, 1'b0,
          {16'h0100, 16'h0100, 16'h7F00, {5{16'h0100}}},
          {8{16'h0100}});
    @(negedge clk);
    chk("ovf_lane_a_b0", 128'(lane_a), {4{16'h0100}});
    chk("ovf_lane_op", 128'(lane_opcode), 128'd2);
    @(negedge clk);
    chk("ovf_lane_a_b1", 128'(lane_a),
        {16'h0100, 16'h0100, 16'h7F00, 16'h0100});
    chk("ovf_valid_c2", 128'(bus.out_valid), 128'd0);
    @(negedge clk);
    chk("ovf_valid_c3", 128'(bus.out_valid), 128'd1);
    chk("ovf_result", bus.out_result,
        {16'h0200, 16'h0200, 16'h8000, {5{16'h0200}}});
    chk("ovf_flags", 128'(bus.out_flags), 128'b1100);
    accept("ovf");

    // reset during beat 1 aborts the instruction
    issue(3'b010, 1'b0, {8{16'h0100}}, {8{16'h0080}});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", 128'(bus.out_valid), 128'd0);
    chk("abort_result", bus.out_result, 128'd0);
    chk("abort_in_ready", 128'(bus.in_ready), 128'd1);
    chk("abort_flags", 128'(bus.out_flags), 128'd0);
    @(negedge clk);
    chk("abort_no_pulse", 128'(bus.out_valid), 128'd0);

    // vector sub, equal operands
    issue(3'b001, 1'b0, {8{16'h0100}}, {8{16'h0100}});
    wait_lat(3, "vsub");
    chk("vsub_result", bus.out_result, 128'd0);
    chk("vsub_flags", 128'(bus.out_flags), 128'b0011);
    accept("vsub");

    // invalid opcode
    issue(3'b111, 1'b0, {8{16'h1234}}, {8{16'h4321}});
    wait_lat(3, "inv");
    chk("inv_result", bus.out_result, 128'd0);
    chk("inv_flags", 128'(bus.out_flags), 128'b0010);
    accept("inv");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
